// File: rtl/echo_delay_sched_if.sv
// Sample-path and RAM-bus signals of the echo delay-line sequencer.
// The sequencer uses the master view; the audio path and sample RAM use the slave view.
interface echo_delay_sched_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 10
);
   logic              tick;
   logic              trigger;
   logic [ADDR_W-1:0] delay_len;
   logic [DATA_W-1:0] sample_in;
   logic [DATA_W-1:0] ram_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] sample_out;
   logic              out_valid;
   logic              time_out;
   logic              busy;
   logic              overrun;
   logic [1:0]        state_dbg;

   modport master (
      input  tick, trigger, delay_len, sample_in, ram_rdata,
      output ram_addr, ram_wdata, ram_we, sample_out, out_valid,
             time_out, busy, overrun, state_dbg
   );

   modport slave (
      output tick, trigger, delay_len, sample_in, ram_rdata,
      input  ram_addr, ram_wdata, ram_we, sample_out, out_valid,
             time_out, busy, overrun, state_dbg
   );
endinterface

// File: rtl/echo_delay_sched.sv
// Echo delay-line sequencer: per sample tick, one write and one delayed read of a
// single-port sample RAM, with arm / fill / run / time_out control.
module echo_delay_sched #(
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 10,
   parameter int RUN_TICKS = 24000
) (
   input logic                clk,
   input logic                rst_n,
   echo_delay_sched_if.master bus
);
   localparam int                RUN_W    = $clog2(RUN_TICKS + 1);
   localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(RUN_TICKS - 1);
   localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
   typedef enum logic [1:0] {SLOT_NONE = 2'd0, SLOT_S1 = 2'd1, SLOT_S2 = 2'd2, SLOT_S3 = 2'd3} slot_t;

   state_t            state_reg, state_next;
   slot_t             slot_reg, slot_next;
   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] fill_cnt_reg, fill_cnt_next;
   logic [ADDR_W-1:0] dly_reg, dly_next;
   logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;
   logic [DATA_W-1:0] smp_reg;
   logic [DATA_W-1:0] out_hold_reg;
   logic [DATA_W-1:0] out_sel;
   logic [ADDR_W-1:0] addr_hold_reg;
   logic [ADDR_W-1:0] addr_cur;
   logic [ADDR_W-1:0] rd_ptr;
   logic              overrun_reg;
   logic              tick_ok;
   logic              in_s3;
   logic              final_s3;

   assign tick_ok  = bus.tick && (slot_reg == SLOT_NONE);
   assign in_s3    = (slot_reg == SLOT_S3);
   assign rd_ptr   = wr_ptr_reg - dly_reg;
   assign final_s3 = in_s3 && (state_reg == RUN) && (run_cnt_reg == RUN_LAST);

   always_comb begin
      slot_next = slot_reg;
      unique case (slot_reg)
         SLOT_NONE: if (bus.tick) slot_next = SLOT_S1;
         SLOT_S1:   slot_next = SLOT_S2;
         SLOT_S2:   slot_next = SLOT_S3;
         SLOT_S3:   slot_next = SLOT_NONE;
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      wr_ptr_next   = wr_ptr_reg;
      fill_cnt_next = fill_cnt_reg;
      run_cnt_next  = run_cnt_reg;
      dly_next      = dly_reg;
      unique case (state_reg)
         IDLE: begin
            if (bus.trigger && (slot_reg == SLOT_NONE)) begin
               state_next    = FILL;
               dly_next      = (bus.delay_len == '0) ? ADDR_ONE : bus.delay_len;
               wr_ptr_next   = '0;
               fill_cnt_next = '0;
            end
         end
         FILL: begin
            if (in_s3) begin
               wr_ptr_next   = wr_ptr_reg + ADDR_ONE;
               fill_cnt_next = fill_cnt_reg + ADDR_ONE;
               if (fill_cnt_reg + ADDR_ONE == dly_reg) begin
                  state_next   = RUN;
                  run_cnt_next = '0;
               end
            end
         end
         RUN: begin
            if (in_s3) begin
               wr_ptr_next  = wr_ptr_reg + ADDR_ONE;
               run_cnt_next = run_cnt_reg + RUN_ONE;
               if (final_s3 && !bus.trigger) state_next = IDLE;
            end
            // A re-trigger extends the echo and beats a coincident end of run.
            if (bus.trigger) run_cnt_next = '0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      addr_cur = addr_hold_reg;
      unique case (slot_reg)
         SLOT_S1: addr_cur = wr_ptr_reg;
         SLOT_S2: addr_cur = rd_ptr;
         default: addr_cur = addr_hold_reg;
      endcase
   end

   always_comb begin
      out_sel = '0;
      unique case (state_reg)
         IDLE:    out_sel = smp_reg;
         FILL:    out_sel = '0;
         RUN:     out_sel = bus.ram_rdata;
         default: out_sel = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         slot_reg      <= SLOT_NONE;
         wr_ptr_reg    <= '0;
         fill_cnt_reg  <= '0;
         run_cnt_reg   <= '0;
         dly_reg       <= ADDR_ONE;
         smp_reg       <= '0;
         out_hold_reg  <= '0;
         addr_hold_reg <= '0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         slot_reg      <= slot_next;
         wr_ptr_reg    <= wr_ptr_next;
         fill_cnt_reg  <= fill_cnt_next;
         run_cnt_reg   <= run_cnt_next;
         dly_reg       <= dly_next;
         addr_hold_reg <= addr_cur;
         if (tick_ok) smp_reg <= bus.sample_in;
         if (in_s3) out_hold_reg <= out_sel;
         if (bus.tick && (slot_reg != SLOT_NONE)) overrun_reg <= 1'b1;
      end
   end

   // Strobes decode from async-reset registers, so reset silences the RAM at once.
   assign bus.ram_addr   = addr_cur;
   assign bus.ram_wdata  = smp_reg;
   assign bus.ram_we     = (slot_reg == SLOT_S1) && (state_reg != IDLE);
   assign bus.sample_out = in_s3 ? out_sel : out_hold_reg;
   assign bus.out_valid  = in_s3;
   assign bus.time_out   = final_s3 && !bus.trigger;
   assign bus.busy       = (state_reg != IDLE);
   assign bus.overrun    = overrun_reg;
   assign bus.state_dbg  = state_reg;
endmodule

// File: tb/tb_echo_delay_sched.sv
// Scoreboard bench for echo_delay_sched: a delay-line model predicts every output
// sample and time_out; RAM strobes and state are checked inside each slot.
module tb_echo_delay_sched;
   localparam int ADDR_W    = 13;
   localparam int DATA_W    = 10;
   localparam int RUN_TICKS = 8;
   localparam int AMASK     = (1 << ADDR_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   echo_delay_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   echo_delay_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_TICKS(RUN_TICKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Single-port synchronous RAM, data one clock after the address.
   logic [DATA_W-1:0] mem [0:AMASK];
   logic [DATA_W-1:0] rdata_q;
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      rdata_q <= mem[bus.ram_addr];
   end
   assign bus.ram_rdata = rdata_q;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   logic [DATA_W-1:0] exp_smp[$];
   bit                exp_to[$];
   int                hist[$];
   int m_state = 0;
   int m_dly   = 1;
   int m_cnt   = 0;
   int m_run   = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) begin
            if (exp_smp.size() == 0) begin
               check("sb_unexpected_out", 32'(bus.sample_out), 32'hFFFF_FFFF);
            end else begin
               check("sample_out", 32'(bus.sample_out), 32'(exp_smp.pop_front()));
               check("time_out", 32'(bus.time_out), 32'(exp_to.pop_front()));
            end
         end else if (bus.time_out) begin
            check("time_out_stray", 32'(bus.time_out), 32'd0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_tick(input logic [DATA_W-1:0] s, input bit trig_s3);
      int n;
      int pst;
      logic [DATA_W-1:0] e;
      bit to;
      pst = m_state;
      n   = hist.size();
      to  = 1'b0;
      e   = '0;
      if (m_state == 0) begin
         e = s;
      end else begin
         hist.push_back(int'(s));
         if (m_state == 1) begin
            m_cnt++;
            if (m_cnt == m_dly) begin
               m_state = 2;
               m_run   = 0;
            end
         end else begin
            e  = DATA_W'(hist[n - m_dly]);
            to = (m_run == RUN_TICKS - 1) && !trig_s3;
            if (to) m_state = 0;
            else if (trig_s3) m_run = 0;
            else m_run++;
         end
      end
      exp_smp.push_back(e);
      exp_to.push_back(to);

      bus.tick      = 1'b1;
      bus.sample_in = s;
      cyc();
      bus.tick = 1'b0;
      @(negedge clk);
      check("we_s1", 32'(bus.ram_we), 32'(pst != 0));
      if (pst != 0) check("wr_addr", 32'(bus.ram_addr), 32'(n & AMASK));
      cyc();
      @(negedge clk);
      check("we_s2", 32'(bus.ram_we), 32'd0);
      if (pst != 0) check("rd_addr", 32'(bus.ram_addr), 32'((n - m_dly) & AMASK));
      cyc();
      if (trig_s3) bus.trigger = 1'b1;
      @(posedge clk);
      #1;
      check("state_after", 32'(bus.state_dbg), 32'(m_state));
      check("busy_after", 32'(bus.busy), 32'(m_state != 0));
      #1;
      bus.trigger = 1'b0;
   endtask

   task automatic arm(input int d);
      bus.delay_len = ADDR_W'(d);
      bus.trigger   = 1'b1;
      cyc();
      bus.trigger = 1'b0;
      m_state = 1;
      m_dly   = (d == 0) ? 1 : d;
      m_cnt   = 0;
      hist.delete();
      @(negedge clk);
      check("arm_state", 32'(bus.state_dbg), 32'd1);
      bus.delay_len = ADDR_W'(13'h0AB);
      cyc();
   endtask

   task automatic pulse_trig();
      bus.trigger = 1'b1;
      cyc();
      bus.trigger = 1'b0;
      if (m_state == 2) m_run = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.tick      = 1'b0;
      bus.trigger   = 1'b0;
      bus.delay_len = '0;
      bus.sample_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", 32'(bus.state_dbg), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_we", 32'(bus.ram_we), 32'd0);
      check("rst_addr", 32'(bus.ram_addr), 32'd0);
      check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
      check("rst_out", 32'(bus.sample_out), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_timeout", 32'(bus.time_out), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      rst_n = 1'b1;
      cyc();

      do_tick(10'h155, 1'b0);
      do_tick(10'h0F0, 1'b0);

      arm(4);
      for (int i = 1; i <= 12; i++) do_tick(DATA_W'(i), 1'b0);

      arm(1);
      for (int i = 1; i <= 6; i++) do_tick(DATA_W'(i + 20), 1'b0);
      pulse_trig();
      for (int i = 1; i <= 8; i++) do_tick(DATA_W'(i + 40), 1'b0);

      arm(0);
      for (int i = 1; i <= 8; i++) do_tick(DATA_W'(i + 100), 1'b0);
      do_tick(10'h3C3, 1'b1);
      for (int i = 1; i <= 8; i++) do_tick(DATA_W'(i + 200), 1'b0);

      @(negedge clk);
      check("overrun_clear", 32'(bus.overrun), 32'd0);
      cyc();

      exp_smp.push_back(10'h2AA);
      exp_to.push_back(1'b0);
      bus.tick      = 1'b1;
      bus.sample_in = 10'h2AA;
      cyc();
      bus.tick = 1'b0;
      cyc();
      bus.tick      = 1'b1;
      bus.sample_in = 10'h111;
      cyc();
      bus.tick = 1'b0;
      cyc();
      @(negedge clk);
      check("overrun_set", 32'(bus.overrun), 32'd1);
      repeat (3) cyc();
      do_tick(10'h077, 1'b0);
      @(negedge clk);
      check("overrun_sticky", 32'(bus.overrun), 32'd1);
      cyc();

      arm(3);
      bus.tick      = 1'b1;
      bus.sample_in = 10'h05A;
      cyc();
      bus.tick = 1'b0;
      @(negedge clk);
      check("we_before_rst", 32'(bus.ram_we), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("we_async_rst", 32'(bus.ram_we), 32'd0);
      check("state_async_rst", 32'(bus.state_dbg), 32'd0);
      check("overrun_async_rst", 32'(bus.overrun), 32'd0);
      exp_smp.delete();
      exp_to.delete();
      m_state = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      do_tick(10'h1E1, 1'b0);
      repeat (2) cyc();

      check("sb_drained", 32'(exp_smp.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/echo_delay_sched.md
Name: echo_delay_sched

Overview:
- Sequences a single-port sample RAM used as a voice delay line (echo effect).
- On each audio sample strobe it schedules one write of the incoming sample and one read of the delayed sample.
- A trigger arms the effect; a run countdown ends it and raises time_out for the downstream effect FSM.
- Sits between the audio sample path and the external sample RAM, in the single system clock domain.

Parameters:
ADDR_W, 13, RAM address width; delay line depth is 2^ADDR_W samples
DATA_W, 10, sample width
RUN_TICKS, 24000, number of output samples produced in RUN before time_out

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
tick  in  1  sample strobe, one clk wide
trigger  in  1  arm request, level, sampled on clk
delay_len  in  ADDR_W  echo delay in samples, latched on arm
sample_in  in  DATA_W  input sample, valid with tick
ram_rdata  in  DATA_W  RAM read data, valid 1 clk after read address
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
sample_out  out  DATA_W  output sample
out_valid  out  1  one-clk pulse, sample_out valid
time_out  out  1  one-clk pulse at end of RUN
busy  out  1  high in FILL or RUN
overrun  out  1  sticky: tick arrived while access slot busy
state_dbg  out  2  current state: 0 IDLE, 1 FILL, 2 RUN

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_ptr=0, fill_cnt=0, run_cnt=0; all outputs 0. Reset mid-sequence aborts any RAM access: ram_we is forced low immediately.
- Access slot (per accepted tick; slot phases S0..S3, idle otherwise):
  - S0 (tick cycle): capture sample_in into smp_q.
  - S1: if state is not IDLE, drive ram_we=1, ram_addr=wr_ptr, ram_wdata=smp_q.
  - S2: ram_we=0, ram_addr=rd_ptr, where rd_ptr=(wr_ptr - dly_q) mod 2^ADDR_W (ADDR_W-bit wrap arithmetic).
  - S3: capture output and pulse out_valid.
  - out_valid rises exactly 3 clks after the tick cycle.
  - wr_ptr increments (wraps at 2^ADDR_W-1 -> 0) at S3 in FILL/RUN only.
- Tick during S1..S3: dropped and overrun set to 1. overrun clears only on reset. A tick in S3's following cycle is accepted normally.
- S3 output select:
  - IDLE: sample_out=smp_q (dry passthrough).
  - FILL: sample_out=0.
  - RUN: sample_out=ram_rdata.
- ram_addr holds its last value outside S1/S2; ram_we is high only in S1.
- State machine (transitions take effect on clk edge, never inside a slot):
  - IDLE -> FILL: trigger=1 while no slot active. Latch dly_q = delay_len, with 0 clamped to 1. Clear wr_ptr and fill_cnt.
  - FILL: fill_cnt increments at each S3. When fill_cnt reaches dly_q, go to RUN at that S3 and clear run_cnt. The first RUN read returns the sample written dly_q ticks earlier.
  - RUN: run_cnt increments at each S3. At the S3 where run_cnt reaches RUN_TICKS-1, pulse time_out in the same cycle as out_valid, then go to IDLE.
  - Trigger in RUN restarts run_cnt to 0 (extends the echo); dly_q is unchanged.
  - Trigger in FILL is ignored.
  - Trigger held high when returning to IDLE re-arms on the next cycle.
- A trigger and the final-S3 time_out in the same cycle: the restart wins. run_cnt goes to 0, time_out is not pulsed, and the state stays RUN.
- delay_len changes after arming have no effect until the next arm.
- busy = (state != IDLE).

Test Plan:
- Reset with tick and trigger idle -> all outputs 0, state_dbg=0. Assert rst_n low during S1 -> ram_we drops to 0 in the same cycle, not at the next edge.
- IDLE, tick with sample_in=0x155 -> out_valid exactly 3 clks later with sample_out=0x155, ram_we never high.
- delay_len=4, trigger, then ticks carrying 1,2,3,...:
  - first 4 outputs are 0 (FILL);
  - 5th output is 1, 6th is 2;
  - write addresses run 0,1,2,...; read addresses wrap (first read at 0x1FFC for ADDR_W=13).
- RUN_TICKS=8 (overridden), delay_len=1 -> time_out pulses coincident with the 8th RUN out_valid; state_dbg returns to 0 the next cycle.
- Trigger pulse at RUN sample 5 -> run_cnt restarts; time_out occurs 8 RUN outputs after the restart. Trigger coincident with the final S3 -> no time_out, state stays RUN.
- Two ticks 2 clks apart -> second tick dropped, overrun=1 and stays 1. delay_len=0 on arm -> behaves as delay 1.
